// File: rtl/disp_pkg.sv
// disp_pkg
//
// Purpose: shared constants and helpers for the display scan multiplexer.
//   clog2      - ceiling log2, usable in parameter/localparam expressions.
//   ANODE_OFF  - all-ones anode pattern (every digit dark); slice to DIGITS bits.
//   get_digit  - extracts one nibble from a packed multi-source BCD bus.
//
// Ports: none (package).

package disp_pkg;

    // Upper bounds for the generic helpers. The packed source bus is
    // zero-extended to MAX_BUS bits before nibble extraction, and nibbles
    // are returned in MAX_W bits for the caller to cast down to W.
    localparam int MAX_BUS    = 1024;
    localparam int MAX_W      = 16;
    localparam int MAX_DIGITS = 32;

    // Active-low anodes: all ones means nothing is lit.
    localparam logic [MAX_DIGITS-1:0] ANODE_OFF = '1;

    // Ceiling log2 with a fixed loop bound so it stays elaboration-friendly.
    function automatic int clog2(input int value);
        int result;
        result = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < value) begin
                result = i + 1;
            end
        end
        return result;
    endfunction

    // Source ch, digit d lives at bit offset (ch*digits + d)*w; digit 0 is
    // the least significant nibble of each source.
    function automatic logic [MAX_W-1:0] get_digit(
        input logic [MAX_BUS-1:0] src_data,
        input int                 ch,
        input int                 d,
        input int                 digits,
        input int                 w
    );
        logic [MAX_BUS-1:0] shifted;
        logic [MAX_W-1:0]   mask;
        shifted = src_data >> ((ch * digits + d) * w);
        mask    = (MAX_W'(1) << w) - MAX_W'(1);
        return shifted[MAX_W-1:0] & mask;
    endfunction

endpackage

// File: rtl/disp_scan_tick.sv
// disp_scan_tick
//
// Purpose: digit-slot prescaler. Counts 0..SCAN_DIV-1 and wraps; slot_tick
//   is high for the whole cycle in which the count sits at SCAN_DIV-1, so
//   each digit slot lasts exactly SCAN_DIV clock cycles.
//
// Ports:
//   clk        in   system clock
//   rst_n      in   asynchronous active-low reset (count returns to 0)
//   slot_tick  out  end-of-slot strobe (combinational from the count)

module disp_scan_tick
    import disp_pkg::*;
#(
    parameter int SCAN_DIV = 50000
) (
    input  logic clk,
    input  logic rst_n,
    output logic slot_tick
);

    localparam int              PW   = clog2(SCAN_DIV);
    localparam logic [PW-1:0]   LAST = PW'(SCAN_DIV - 1);

    logic [PW-1:0] prescaler;

    assign slot_tick = (prescaler == LAST);

    // The wrap is an explicit compare so non-power-of-two dividers work.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prescaler <= '0;
        end else if (slot_tick) begin
            prescaler <= '0;
        end else begin
            prescaler <= prescaler + PW'(1);
        end
    end

endmodule

// File: rtl/disp_scan_mux.sv
// disp_scan_mux
//
// Purpose: picks one of NCH packed BCD sources and time-multiplexes its
//   DIGITS nibbles onto a shared 7-segment digit bus with one-hot
//   active-low anodes. The displayed source only changes on a frame
//   boundary, either from the manual select or by automatic rotation
//   every ROT_FRAMES frames.
//
// Optional feature: define DISP_SCAN_LEADING_ZERO_BLANK_EN to darken
//   leading zeros (digit 0 is always lit). Without it every digit is driven.
//
// Ports:
//   clk         in   system clock
//   rst_n       in   asynchronous active-low reset
//   src_data    in   NCH*DIGITS*W packed sources, source c digit d at
//                    bits [(c*DIGITS+d)*W +: W], sampled live every cycle
//   sel         in   manual source select (values >= NCH are ignored)
//   auto_en     in   1 = rotate sources automatically, 0 = manual
//   digit_out   out  nibble for the lit digit (registered)
//   an          out  active-low one-hot anodes (registered)
//   ch_active   out  source currently displayed (registered)
//   frame_tick  out  one-cycle pulse after the last slot of a frame

module disp_scan_mux
    import disp_pkg::*;
#(
    parameter  int W          = 4,
    parameter  int DIGITS     = 4,
    parameter  int NCH        = 2,
    parameter  int SCAN_DIV   = 50000,
    parameter  int ROT_FRAMES = 250,
    localparam int CW         = clog2(NCH)
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [NCH*DIGITS*W-1:0] src_data,
    input  logic [CW-1:0]           sel,
    input  logic                    auto_en,
    output logic [W-1:0]            digit_out,
    output logic [DIGITS-1:0]       an,
    output logic [CW-1:0]           ch_active,
    output logic                    frame_tick
);

    localparam int IDXW = clog2(DIGITS);
    localparam int FCW  = clog2(ROT_FRAMES + 1);

    localparam logic [IDXW-1:0] LAST_DIGIT = IDXW'(DIGITS - 1);
    localparam logic [FCW-1:0]  LAST_FRAME = FCW'(ROT_FRAMES - 1);
    localparam logic [CW-1:0]   LAST_CH    = CW'(NCH - 1);
    // One bit wider than sel so the range check also works when NCH is a
    // power of two.
    localparam logic [CW:0]     SEL_LIMIT  = (CW + 1)'(NCH);

    logic                 slot_tick;
    logic                 frame_end;
    logic [IDXW-1:0]      digit_idx;
    logic [FCW-1:0]       frame_cnt;
    logic [MAX_BUS-1:0]   src_ext;
    logic [W-1:0]         cur_digit;
    logic                 blank_digit;
`ifdef DISP_SCAN_LEADING_ZERO_BLANK_EN
    logic                 upper_zero;
`endif

    disp_scan_tick #(
        .SCAN_DIV (SCAN_DIV)
    ) u_tick (
        .clk       (clk),
        .rst_n     (rst_n),
        .slot_tick (slot_tick)
    );

    assign frame_end = slot_tick && (digit_idx == LAST_DIGIT);
    assign src_ext   = MAX_BUS'(src_data);

    // Digit index steps once per slot and wraps after the last digit.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            digit_idx <= '0;
        end else if (slot_tick) begin
            if (digit_idx == LAST_DIGIT) begin
                digit_idx <= '0;
            end else begin
                digit_idx <= digit_idx + IDXW'(1);
            end
        end
    end

    // Source selection is only re-evaluated at frame end so a frame never
    // mixes digits from two sources. In manual mode the frame counter is
    // parked at 0, so switching to auto always starts a fresh count.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ch_active <= '0;
            frame_cnt <= '0;
        end else if (frame_end) begin
            if (auto_en) begin
                if (frame_cnt == LAST_FRAME) begin
                    frame_cnt <= '0;
                    if (ch_active == LAST_CH) begin
                        ch_active <= '0;
                    end else begin
                        ch_active <= ch_active + CW'(1);
                    end
                end else begin
                    frame_cnt <= frame_cnt + FCW'(1);
                end
            end else begin
                frame_cnt <= '0;
                if ({1'b0, sel} < SEL_LIMIT) begin
                    ch_active <= sel;
                end
            end
        end
    end

    // Nibble for the current slot. With leading-zero blanking, a digit above
    // 0 goes dark when it and every more significant digit are zero, judged
    // on the same cycle's source data as the digit value itself.
    always_comb begin
        cur_digit   = W'(get_digit(src_ext, int'(ch_active), int'(digit_idx), DIGITS, W));
        blank_digit = 1'b0;
`ifdef DISP_SCAN_LEADING_ZERO_BLANK_EN
        upper_zero = 1'b1;
        for (int k = 0; k < DIGITS; k++) begin
            if ((k >= int'(digit_idx)) &&
                (get_digit(src_ext, int'(ch_active), k, DIGITS, W) != '0)) begin
                upper_zero = 1'b0;
            end
        end
        blank_digit = upper_zero && (digit_idx != '0);
`endif
    end

    // Output register: one cycle behind the index/channel, anodes dark in
    // reset so the display stays blank until the first post-reset edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            digit_out  <= '0;
            an         <= ANODE_OFF[DIGITS-1:0];
            frame_tick <= 1'b0;
        end else begin
            frame_tick <= frame_end;
            if (blank_digit) begin
                digit_out <= '0;
                an        <= ANODE_OFF[DIGITS-1:0];
            end else begin
                digit_out <= cur_digit;
                an        <= ~(DIGITS'(1) << digit_idx);
            end
        end
    end

endmodule

// File: tb/tb_disp_scan_mux.sv
// tb_disp_scan_mux
//
// Purpose: self-checking bench for disp_scan_mux with SCAN_DIV=4, DIGITS=4,
//   NCH=3, ROT_FRAMES=2, W=4. A frame-level reference model tracks the
//   position inside the frame and the displayed source; a negedge process
//   compares every DUT output against it each cycle, and directed sections
//   pin the model with hand-computed values.

module tb_disp_scan_mux;

    localparam int W          = 4;
    localparam int DIGITS     = 4;
    localparam int NCH        = 3;
    localparam int SCAN_DIV   = 4;
    localparam int ROT_FRAMES = 2;
    localparam int CW         = 2;
    localparam int FRAME      = DIGITS * SCAN_DIV;

    logic                    clk;
    logic                    rst_n;
    logic [NCH*DIGITS*W-1:0] src_data;
    logic [CW-1:0]           sel;
    logic                    auto_en;
    logic [W-1:0]            digit_out;
    logic [DIGITS-1:0]       an;
    logic [CW-1:0]           ch_active;
    logic                    frame_tick;

    logic [15:0] src [NCH];

    int n_checks;
    int n_fail;
    bit checking;

    // Reference model state: cycle position within the frame, displayed
    // source, and frames already shown on that source in auto mode.
    int          m_cyc;
    int          m_ch;
    int          m_fc;
    logic [3:0]  e_an;
    logic [3:0]  e_digit;
    logic        e_tick;

    assign src_data = {src[2], src[1], src[0]};

    disp_scan_mux #(
        .W          (W),
        .DIGITS     (DIGITS),
        .NCH        (NCH),
        .SCAN_DIV   (SCAN_DIV),
        .ROT_FRAMES (ROT_FRAMES)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .src_data   (src_data),
        .sel        (sel),
        .auto_en    (auto_en),
        .digit_out  (digit_out),
        .an         (an),
        .ch_active  (ch_active),
        .frame_tick (frame_tick)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // A digit is dark under blanking when it and everything above it are zero.
    function automatic bit lead_blank(input int ch, input int d);
`ifdef DISP_SCAN_LEADING_ZERO_BLANK_EN
        return (d > 0) && ((src[ch] >> (W * d)) == 16'h0);
`else
        return (ch < 0) && (d < 0);
`endif
    endfunction

    function automatic logic [3:0] model_an(input int ch, input int cyc);
        int d;
        d = cyc / SCAN_DIV;
        if (lead_blank(ch, d)) return 4'hF;
        return ~(4'b0001 << d);
    endfunction

    function automatic logic [3:0] model_digit(input int ch, input int cyc);
        int d;
        d = cyc / SCAN_DIV;
        if (lead_blank(ch, d)) return 4'h0;
        return 4'((src[ch] >> (W * d)) & 16'hF);
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_cyc   <= 0;
            m_ch    <= 0;
            m_fc    <= 0;
            e_an    <= 4'hF;
            e_digit <= 4'h0;
            e_tick  <= 1'b0;
        end else begin
            e_an    <= model_an(m_ch, m_cyc);
            e_digit <= model_digit(m_ch, m_cyc);
            e_tick  <= (m_cyc == FRAME - 1);
            if (m_cyc == FRAME - 1) begin
                m_cyc <= 0;
                if (auto_en) begin
                    if (m_fc + 1 == ROT_FRAMES) begin
                        m_fc <= 0;
                        m_ch <= (m_ch + 1) % NCH;
                    end else begin
                        m_fc <= m_fc + 1;
                    end
                end else begin
                    m_fc <= 0;
                    if (int'(sel) < NCH) m_ch <= int'(sel);
                end
            end else begin
                m_cyc <= m_cyc + 1;
            end
        end
    end

    task automatic checkOutput(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
        end
    endtask

    task automatic applyStimulus(input logic [15:0] s0, input logic [15:0] s1,
                                 input logic [15:0] s2, input logic [CW-1:0] s,
                                 input logic a);
        src[0]  = s0;
        src[1]  = s1;
        src[2]  = s2;
        sel     = s;
        auto_en = a;
    endtask

    task automatic waitFrameTick();
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (frame_tick !== 1'b1 && n < 4 * FRAME);
        if (frame_tick !== 1'b1) checkOutput("frame_tick_timeout", 32'(frame_tick), 32'd1);
    endtask

    always @(negedge clk) begin
        if (checking) begin
            checkOutput("an", 32'(an), 32'(e_an));
            checkOutput("digit_out", 32'(digit_out), 32'(e_digit));
            checkOutput("frame_tick", 32'(frame_tick), 32'(e_tick));
            checkOutput("ch_active", 32'(ch_active), 32'(m_ch));
        end
    end

    initial begin
        logic [3:0] an_tab  [4];
        logic [3:0] dig_tab [4];
        int blanks;
        int lit5;

        an_tab  = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};
        dig_tab = '{4'h4, 4'h3, 4'h2, 4'h1};
        n_checks = 0;
        n_fail   = 0;
        checking = 1'b0;
        rst_n    = 1'b0;
        applyStimulus(16'h1234, 16'hABCD, 16'h5678, 2'd0, 1'b0);

        repeat (3) @(negedge clk);
        checking = 1'b1;
        checkOutput("reset_an", 32'(an), 32'hF);
        checkOutput("reset_digit", 32'(digit_out), 32'h0);
        checkOutput("reset_ch", 32'(ch_active), 32'h0);
        checkOutput("reset_tick", 32'(frame_tick), 32'h0);

        // First frame after release: 4 cycles per digit, tick on the last.
        #2 rst_n = 1'b1;
        for (int k = 0; k < FRAME; k++) begin
            @(negedge clk);
            checkOutput("scan_an", 32'(an), 32'(an_tab[k / 4]));
            checkOutput("scan_digit", 32'(digit_out), 32'(dig_tab[k / 4]));
            checkOutput("model_an", 32'(e_an), 32'(an_tab[k / 4]));
            checkOutput("scan_tick", 32'(frame_tick), (k == FRAME - 1) ? 32'd1 : 32'd0);
        end

        // Manual switch to source 2 in cycle 5 of a frame.
        repeat (5) @(negedge clk);
        applyStimulus(16'h1234, 16'hABCD, 16'h5678, 2'd2, 1'b0);
        @(negedge clk);
        checkOutput("manual_hold", 32'(ch_active), 32'd0);
        waitFrameTick();
        checkOutput("manual_switch", 32'(ch_active), 32'd2);
        @(negedge clk);
        checkOutput("manual_src2_digit0", 32'(digit_out), 32'h8);

        // Out-of-range select leaves the channel alone.
        applyStimulus(16'h1234, 16'hABCD, 16'h5678, 2'd3, 1'b0);
        repeat (3) waitFrameTick();
        checkOutput("sel_out_of_range", 32'(ch_active), 32'd2);

        // Auto rotation: two frames per source.
        auto_en = 1'b1;
        repeat (2) waitFrameTick();
        checkOutput("auto_rot_0", 32'(ch_active), 32'd0);
        repeat (2) waitFrameTick();
        checkOutput("auto_rot_1", 32'(ch_active), 32'd1);
        repeat (2) waitFrameTick();
        checkOutput("auto_rot_2", 32'(ch_active), 32'd2);
        repeat (5) @(negedge clk);
        applyStimulus(16'h1234, 16'hABCD, 16'h5678, 2'd1, 1'b0);
        waitFrameTick();
        checkOutput("auto_off_sel1", 32'(ch_active), 32'd1);

        // Asynchronous reset mid-frame.
        repeat (7) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        checkOutput("async_reset_an", 32'(an), 32'hF);
        checkOutput("async_reset_ch", 32'(ch_active), 32'd0);
        applyStimulus(16'h1234, 16'hABCD, 16'h5678, 2'd0, 1'b0);
        @(negedge clk);
        #2 rst_n = 1'b1;
        @(negedge clk);
        checkOutput("restart_an", 32'(an), 32'b1110);
        checkOutput("restart_digit", 32'(digit_out), 32'h4);

        // Leading zeros on source 0.
        waitFrameTick();
        applyStimulus(16'h0050, 16'hABCD, 16'h5678, 2'd0, 1'b0);
        blanks = 0;
        lit5   = 0;
        for (int k = 0; k < FRAME; k++) begin
            @(negedge clk);
            if (an == 4'hF) blanks++;
            if (an == 4'b1101 && digit_out == 4'h5) lit5++;
        end
`ifdef DISP_SCAN_LEADING_ZERO_BLANK_EN
        checkOutput("lz_0050_blanks", 32'(blanks), 32'd8);
`else
        checkOutput("lz_0050_blanks", 32'(blanks), 32'd0);
`endif
        checkOutput("lz_0050_digit1", 32'(lit5), 32'd4);
        applyStimulus(16'h0000, 16'hABCD, 16'h5678, 2'd0, 1'b0);
        blanks = 0;
        for (int k = 0; k < FRAME; k++) begin
            @(negedge clk);
            if (an == 4'hF) blanks++;
        end
`ifdef DISP_SCAN_LEADING_ZERO_BLANK_EN
        checkOutput("lz_0000_blanks", 32'(blanks), 32'd12);
`else
        checkOutput("lz_0000_blanks", 32'(blanks), 32'd0);
`endif

        // Randomized traffic: live source data, occasional select/mode flips.
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            src[0] = 16'($urandom);
            src[1] = 16'($urandom);
            src[2] = ($urandom_range(0, 3) == 0) ? 16'($urandom_range(0, 255)) : 16'($urandom);
            if ($urandom_range(0, 39) == 0) sel = 2'($urandom_range(0, 3));
            if ($urandom_range(0, 149) == 0) auto_en = ~auto_en;
        end

        @(negedge clk);
        checking = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/disp_scan_mux.md
Name: disp_scan_mux

Overview:
- Parametrised successor to the 2:1 display source selector: picks one of NCH packed BCD sources and time-multiplexes its DIGITS nibbles onto a shared 7-segment bus with one-hot active-low anodes.
- Supports manual source selection and automatic rotation.
- Source changes take effect only on frame boundaries, so a frame never shows digits from two sources.
- Sits between the frequency/counter datapaths and the BCD-to-7-segment decoder.

Parameters:
- W, 4, nibble width per digit.
- DIGITS, 4, digits per source and anode count (≥2).
- NCH, 2, number of sources (≥2).
- SCAN_DIV, 50000, clk cycles per digit slot (≥2).
- ROT_FRAMES, 250, full frames per source in auto mode (≥1).

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous active-low reset.
- src_data  in  NCH*DIGITS*W  packed sources; source c digit d at bits [(c*DIGITS+d)*W +: W]; digit 0 is least significant.
- sel  in  CW=$clog2(NCH)  manual source select.
- auto_en  in  1  1 = auto-rotate, 0 = manual.
- digit_out  out  W  nibble for the currently enabled digit (registered).
- an  out  DIGITS  anodes, active-low, one-hot-low (registered).
- ch_active  out  CW  source currently displayed (registered).
- frame_tick  out  1  one-cycle pulse when the last digit slot of a frame ends.

Behaviour:
- Interface (already decided): one clock, clk; reset rst_n is asynchronous and active-low.
- Reset values: prescaler=0, digit index=0, frame counter=0, ch_active=0, digit_out=0, an=all ones (blank), frame_tick=0.
- Prescaler counts 0..SCAN_DIV-1 and wraps.
  - slot_tick is asserted while prescaler==SCAN_DIV-1.
- On slot_tick, the digit index advances d→d+1.
  - At d==DIGITS-1 it wraps to 0; that tick is the frame end.
- Output register, updated every cycle: digit_out and an reflect the current digit index and ch_active.
  - Latency: 1 cycle from an index/channel change to the outputs.
  - First non-blank an appears 1 cycle after reset release and shows digit 0 of source 0.
- frame_tick is registered: it is high for exactly the one cycle after a frame-end slot_tick.
- Channel update happens only at frame end:
  - Manual (auto_en=0): ch_active ← sel if sel<NCH; otherwise ch_active holds. The frame counter is held at 0.
  - Auto (auto_en=1): the frame counter increments at each frame end.
    - When it reaches ROT_FRAMES-1, it clears and ch_active ← ch_active+1, wrapping NCH-1→0.
- Changes to auto_en or sel mid-frame have no visible effect until the next frame end.
  - auto_en 1→0 clears the frame counter at the next frame end.
  - auto_en 0→1 starts counting from 0.
- src_data is sampled live each cycle; it is not frozen per frame.
- Asserting rst_n mid-frame immediately blanks the anodes and restarts at digit 0, source 0.
- Width rules: prescaler uses $clog2(SCAN_DIV) bits, digit index $clog2(DIGITS), frame counter $clog2(ROT_FRAMES+1). All wraps are explicit compares, never natural overflow.

Optional Feature:
- Macro: DISP_SCAN_LEADING_ZERO_BLANK_EN.
- When defined: digit d>0 is blanked (its an bit stays high, digit_out=0) if every digit of the active source from DIGITS-1 down to d equals 0. Digit 0 is never blanked. The blank decision uses the same cycle's src_data as the digit value.
- When undefined: all digits are always driven, including leading zeros.

Decomposition:
- Package disp_pkg holds:
  - function clog2
  - ANODE_OFF = all-ones constant
  - nibble extraction function get_digit(src_data, ch, d).
- One sub-module, disp_scan_tick: the prescaler generating slot_tick, parameter SCAN_DIV.

Test Plan:
- Bench configuration: SCAN_DIV=4, DIGITS=4, NCH=3, ROT_FRAMES=2, W=4.
- Scenarios:
  - Reset release with src0=0x1234 → an 1110/1101/1011/0111 for 4 cycles each, digit_out 4,3,2,1; frame_tick pulses once per 16 cycles.
  - Manual mode, sel 0→2 at cycle 5 of a frame → ch_active changes only after the frame end; no frame mixes src0 and src2 digits.
  - Manual mode, sel=3 (out of range) → ch_active holds its previous value indefinitely.
  - auto_en=1 → ch_active steps 0→1→2→0 every 2 frames (32 cycles); dropping auto_en with sel=1 → source 1 from the next frame end.
  - rst_n low for 1 cycle mid-frame (async, between clock edges) → an=1111 immediately; restarts at digit 0 of source 0.
  - DISP_SCAN_LEADING_ZERO_BLANK_EN defined, src0=0x0050 → digits 3 and 2 blanked (an high), digits 1 and 0 show 5 and 0; src0=0x0000 → only digit 0 lit, showing 0.
